// File: rtl/trs_stream_generator.sv
// Embedded-sync 8-bit video source: EAV/SAV timing references, blanking fill
// and a selectable active-video test pattern with line/frame valid strobes.
module trs_stream_generator #(
  parameter int unsigned HA = 2560,
  parameter int unsigned HB = 732,
  parameter int unsigned VA = 720,
  parameter int unsigned VB = 30
) (
  input  logic       gen_clk,
  input  logic       gen_rst_n,
  input  logic       en_i,
  input  logic [1:0] pattern_i,
  output logic [7:0] data_o,
  output logic       lv_o,
  output logic       fv_o,
  output logic       frame_start_o,
  output logic       busy_o
);

  localparam int unsigned H_TOTAL   = 4 + HB + 4 + HA;
  localparam int unsigned V_TOTAL   = VB + VA;
  localparam int unsigned HW        = $clog2(H_TOTAL);
  localparam int unsigned VW        = $clog2(V_TOTAL);
  localparam int unsigned SAV_START = 4 + HB;
  localparam int unsigned ACT_START = 8 + HB;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    pat_q, pat_d;
  logic [7:0]    ramp_q, ramp_d;

  logic [7:0] data_d;
  logic       lv_d, fv_d, fs_d, busy_d;

  logic       blank_line, eav_word, sav_word, in_active, a_bit3;
  logic [1:0] trs_idx;
  logic [7:0] xy, fill, line_id, pat_word, word;

  // Word selection for the current counter position
  always_comb begin
    blank_line = v_q < VW'(VB);
    eav_word   = h_q < HW'(4);
    sav_word   = (h_q >= HW'(SAV_START)) && (h_q < HW'(ACT_START));
    in_active  = h_q >= HW'(ACT_START);
    trs_idx    = eav_word ? h_q[1:0] : 2'(h_q - HW'(SAV_START));
    xy         = {1'b1, 1'b0, blank_line, eav_word, blank_line ^ eav_word,
                  eav_word, blank_line, blank_line ^ eav_word};
    // HB is even, so fill and active-word parity both follow h_cnt parity
    fill       = h_q[0] ? 8'h10 : 8'h80;
    a_bit3     = ((h_q - HW'(ACT_START)) & HW'(8)) != '0;
    line_id    = 8'(v_q);
    if (line_id == 8'h00) begin
      line_id = 8'h01;
    end else if (line_id == 8'hFF) begin
      line_id = 8'hFE;
    end

    case (pat_q)
      2'd0:    pat_word = ramp_q;
      2'd1:    pat_word = fill;
      2'd2:    pat_word = a_bit3 ? 8'h10 : 8'hEB;
      default: pat_word = h_q[0] ? 8'h80 : line_id;
    endcase

    if (eav_word || sav_word) begin
      case (trs_idx)
        2'd0:    word = 8'hFF;
        2'd3:    word = xy;
        default: word = 8'h00;
      endcase
    end else if (in_active && !blank_line) begin
      word = pat_word;
    end else begin
      word = fill;
    end
  end

  // Next state, counters and registered-output values
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    pat_d   = pat_q;
    ramp_d  = ramp_q;
    data_d  = 8'h00;
    lv_d    = 1'b0;
    fv_d    = 1'b0;
    fs_d    = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        h_d    = '0;
        v_d    = '0;
        ramp_d = 8'h01;
        if (en_i) begin
          state_d = RUN;
          pat_d   = pattern_i;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        data_d = word;
        fv_d   = !blank_line;
        lv_d   = !blank_line && in_active;
        fs_d   = (h_q == '0) && (v_q == '0);

        // Ramp runs 0x01..0xFE across the active words of a line
        if (h_q == HW'(ACT_START - 1)) begin
          ramp_d = 8'h01;
        end else if (in_active) begin
          ramp_d = (ramp_q == 8'hFE) ? 8'h01 : ramp_q + 8'd1;
        end

        if (h_q == HW'(H_TOTAL - 1)) begin
          h_d = '0;
          if (v_q == VW'(V_TOTAL - 1)) begin
            v_d = '0;
            if (en_i) begin
              pat_d = pattern_i;
            end else begin
              state_d = IDLE;
            end
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          h_d = h_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gen_clk or negedge gen_rst_n) begin
    if (!gen_rst_n) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      pat_q         <= 2'd0;
      ramp_q        <= 8'h01;
      data_o        <= 8'h00;
      lv_o          <= 1'b0;
      fv_o          <= 1'b0;
      frame_start_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pat_q         <= pat_d;
      ramp_q        <= ramp_d;
      data_o        <= data_d;
      lv_o          <= lv_d;
      fv_o          <= fv_d;
      frame_start_o <= fs_d;
      busy_o        <= busy_d;
    end
  end

endmodule

// File: tb/tb_trs_stream_generator.sv
// Scoreboard bench for trs_stream_generator: frame images built from the
// line-layout rules, replayed by a frame-position model under random enables.
module tb_trs_stream_generator;

  localparam int unsigned HA = 8;
  localparam int unsigned HB = 4;
  localparam int unsigned VA = 2;
  localparam int unsigned VB = 1;
  localparam int H_TOTAL = 4 + HB + 4 + HA;
  localparam int V_TOTAL = VB + VA;
  localparam int F_LEN   = H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic [7:0] d;
    logic       lv;
    logic       fv;
    logic       fs;
    logic       busy;
  } obs_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [1:0] pat   = 2'd0;
  logic [7:0] data;
  logic       lv, fv, fs, busy;

  int vectors     = 0;
  int miscompares = 0;

  obs_t img [4][F_LEN];
  obs_t exp_q[$];
  obs_t mon_act, mon_exp;
  bit   mon_en = 1'b0;
  bit   armed  = 1'b0;

  bit m_run = 1'b0;
  int m_pos = 0;
  int m_pat = 0;
  bit count_busy = 1'b0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  trs_stream_generator #(.HA(HA), .HB(HB), .VA(VA), .VB(VB)) dut (
    .gen_clk      (clk),
    .gen_rst_n    (rst_n),
    .en_i         (en),
    .pattern_i    (pat),
    .data_o       (data),
    .lv_o         (lv),
    .fv_o         (fv),
    .frame_start_o(fs),
    .busy_o       (busy)
  );

  function automatic logic [7:0] active_word(input int p, input int line, input int a);
    int id;
    id = line % 256;
    case (p)
      0: return 8'((a % 254) + 1);
      1: return (a % 2 != 0) ? 8'h10 : 8'h80;
      2: return ((a / 8) % 2 == 0) ? 8'hEB : 8'h10;
      default: begin
        if (a % 2 != 0) return 8'h80;
        if (id == 0) id = 1;
        if (id == 255) id = 254;
        return 8'(id);
      end
    endcase
  endfunction

  function automatic logic [7:0] trs_word(input int i, input logic [7:0] xy);
    case (i)
      0:       return 8'hFF;
      3:       return xy;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void build_images();
    for (int p = 0; p < 4; p++) begin
      for (int line = 0; line < V_TOTAL; line++) begin
        bit blank;
        logic [7:0] eav, sav;
        blank = (line < VB);
        eav   = blank ? 8'hB6 : 8'h9D;
        sav   = blank ? 8'hAB : 8'h80;
        for (int h = 0; h < H_TOTAL; h++) begin
          obs_t o;
          int a;
          o.busy = 1'b1;
          o.fv   = !blank;
          o.fs   = (line == 0 && h == 0);
          o.lv   = 1'b0;
          a      = h - (8 + HB);
          if (h < 4)                o.d = trs_word(h, eav);
          else if (h < 4 + HB)      o.d = ((h - 4) % 2 != 0) ? 8'h10 : 8'h80;
          else if (h < 8 + HB)      o.d = trs_word(h - 4 - HB, sav);
          else if (blank)           o.d = (a % 2 != 0) ? 8'h10 : 8'h80;
          else begin
            o.d  = active_word(p, line, a);
            o.lv = 1'b1;
          end
          img[p][line * H_TOTAL + h] = o;
        end
      end
    end
  endfunction

  // One clock of stimulus; queues the output expected after the next edge
  task automatic step(input bit e, input logic [1:0] p);
    obs_t x;
    @(posedge clk);
    #1;
    if (armed) mon_en = 1'b1;
    armed = 1'b1;
    if (count_busy && busy) busy_cnt++;
    en  = e;
    pat = p;
    x = m_run ? img[m_pat][m_pos] : obs_t'(0);
    exp_q.push_back(x);
    if (!m_run) begin
      if (e) begin
        m_run = 1'b1;
        m_pos = 0;
        m_pat = int'(p);
      end
    end else if (m_pos == F_LEN - 1) begin
      if (e) begin
        m_pos = 0;
        m_pat = int'(p);
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if ({data, lv, fv, fs, busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL %s: data=%h lv=%b fv=%b fs=%b busy=%b, required all zero",
               name, data, lv, fv, fs, busy);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_act = {data, lv, fv, fs, busy};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL underflow: output data=%h with no expected word queued", data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL stream @%0t: got d=%h lv=%b fv=%b fs=%b busy=%b, want d=%h lv=%b fv=%b fs=%b busy=%b",
                   $time, mon_act.d, mon_act.lv, mon_act.fv, mon_act.fs, mon_act.busy,
                   mon_exp.d, mon_exp.lv, mon_exp.fv, mon_exp.fs, mon_exp.busy);
        end
      end
      if (lv) begin
        vectors++;
        if (data == 8'h00 || data == 8'hFF) begin
          miscompares++;
          $display("FAIL reserved_in_active: data=%h while lv high, required not 00/FF", data);
        end
      end
    end
  end

  initial begin
    int guard;
    build_images();

    #12;
    check_reset_values("reset_initial");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Continuous frames with ramp, then stripes changing to black mid-frame
    repeat (130) step(1'b1, 2'd0);
    repeat (60)  step(1'b1, 2'd2);
    repeat (100) step(1'b1, 2'd1);
    repeat (80)  step(1'b0, 2'd3);

    // Single-cycle enable pulse: exactly one frame, then idle
    count_busy = 1'b1;
    busy_cnt   = 0;
    step(1'b1, 2'd3);
    repeat (100) step(1'b0, 2'd0);
    count_busy = 1'b0;
    vectors++;
    if (busy_cnt != F_LEN) begin
      miscompares++;
      $display("FAIL busy_length: busy high %0d cycles, required %0d", busy_cnt, F_LEN);
    end
    vectors++;
    if (data !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_hold: data=%h after frame, required 00", data);
    end

    // Randomised enable and pattern
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)));
    end

    // Run into an SAV region, then reset asynchronously
    guard = 0;
    while (!(m_run && (m_pos % H_TOTAL) == 10) && guard < 200) begin
      step(1'b1, 2'd0);
      guard++;
    end
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL sav_search: model never reached SAV within %0d steps", guard);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_async");
    mon_en = 1'b0;
    armed  = 1'b0;
    exp_q.delete();
    m_run  = 1'b0;
    en     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_held");
    rst_n = 1'b1;

    repeat (70) step(1'b1, 2'd3);
    repeat (70) step(1'b0, 2'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trs_stream_generator.md
# trs_stream_generator

Single-clock source of an 8-bit BT.656/SDI-style embedded-sync video stream: EAV and SAV timing reference sequences (FF 00 00 XY), blanking fill, and a selectable active-video test pattern, with matching line-valid and frame-valid strobes. It is the transmit counterpart of the `detector` block. The team uses it as the on-chip stimulus for `detector` and as a fallback video source into the MIPI path when no SDI input is present. Defaults produce 720p timing as 8-bit 4:2:2 words.

## Interface
- `HA`, 2560, active words per line; must be even and ≥ 2.
- `HB`, 732, horizontal blanking fill words between EAV and SAV; must be even and ≥ 2.
- `VA`, 720, active lines per frame; ≥ 1.
- `VB`, 30, vertical-blanking lines per frame; ≥ 1. Blanking lines come first in the frame.
- `gen_clk`  in  1  word clock; one output word per cycle.
- `gen_rst_n`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  run request.
- `pattern_i`  in  2  active-video pattern select; sampled at frame start.
- `data_o`  out  8  stream word.
- `lv_o`  out  1  high on active-video words of active lines.
- `fv_o`  out  1  high on every word of active lines.
- `frame_start_o`  out  1  one-cycle pulse on the first EAV word of each frame.
- `busy_o`  out  1  high while a frame is being emitted.

## Operation
- Line length is `H_TOTAL = 4 + HB + 4 + HA` words.
- Word layout within a line, indexed by `h_cnt`:
  - `h_cnt` 0–3: EAV.
  - `h_cnt` 4 to 3+HB: blanking fill.
  - Next 4 words: SAV.
  - Remaining HA words: active video.
- Frame length is `V_TOTAL = VB + VA` lines. `v_cnt` runs 0 to VB−1 for blanking lines and VB to V_TOTAL−1 for active lines.
- TRS sequence is `FF, 00, 00, XY`. The XY word is built as follows:
  - `XY = {1, F, V, H, V^H, F^H, F^V, F^V^H}`.
  - F = 0 (progressive only).
  - H = 1 for EAV, 0 for SAV.
  - V = 1 on blanking lines, 0 on active lines.
  - Resulting values: SAV active 0x80, EAV active 0x9D, SAV blank 0xAB, EAV blank 0xB6.
- Blanking fill alternates 0x80 (chroma) and 0x10 (luma), starting with 0x80. This applies to the horizontal fill on every line and to the active region of blanking lines.
- Active words of active lines, indexed by `a = h_cnt − (8+HB)`:
  - Pattern 0 (ramp): `(a mod 254) + 1`, range 0x01–0xFE.
  - Pattern 1 (black): 0x80/0x10 alternating.
  - Pattern 2 (stripes): 0xEB for words a[3] = 0, otherwise 0x10.
  - Pattern 3 (line ID): `v_cnt[7:0]` on even a, 0x80 on odd a. 0x00 is replaced by 0x01 and 0xFF by 0xFE.
- Active data never contains 0x00 or 0xFF.
- State machine:
  - **IDLE**: `data_o` = 0x00, counters held at 0, `busy_o` = 0. Moves to RUN when `en_i` = 1.
  - **RUN**: emits the frame from h = 0, v = 0. At the last word of the last line:
    - if `en_i` = 1, wrap to h = 0, v = 0 and stay in RUN;
    - otherwise go to IDLE.
  - Deasserting `en_i` mid-frame never truncates the frame; the current frame always completes.
- `pattern_i` is latched at the IDLE→RUN transition and again at each frame wrap. A mid-frame change takes effect on the next frame.
- Counter width is `$clog2(H_TOTAL)` for `h_cnt` and `$clog2(V_TOTAL)` for `v_cnt`. `h_cnt` wraps at H_TOTAL−1 and `v_cnt` wraps at V_TOTAL−1.
- Reset is asynchronous. Asserting `gen_rst_n` = 0 at any point, including mid-line, forces IDLE and all output reset values immediately.

## Timing
- Reset values: `data_o` = 0x00, `lv_o` = 0, `fv_o` = 0, `frame_start_o` = 0, `busy_o` = 0.
- All outputs are registered. Output lags counter state by 1 cycle; `data_o`, `lv_o`, `fv_o` and `frame_start_o` are mutually aligned.
- First output word:
  - `en_i` sampled high at edge N puts the FSM in RUN with h = 0.
  - The first EAV `FF` appears on `data_o` after edge N+1.
  - `frame_start_o` and `busy_o` rise on that same cycle.
- `lv_o`:
  - rises with the first active word of each active line;
  - falls after the HA-th word;
  - is always exactly HA cycles long.
- `fv_o`:
  - rises on the EAV `FF` of line VB;
  - falls after the last active word of line V_TOTAL−1.
- Back-to-back frames have no gap: the last active word is followed directly by the next frame's EAV `FF`.
- `busy_o` falls on the cycle `data_o` returns to 0x00 after the final frame.

## Test plan
- **Frame structure.** Set HA=8, HB=4, VA=2, VB=1, pattern 0, `en_i` held high. Required response:
  - line 0 = FF 00 00 B6, 80 10 80 10, FF 00 00 AB, then 80 10 ×4;
  - lines 1–2 = FF 00 00 9D, fill, FF 00 00 80, then 01..08;
  - `frame_start_o` every 60 cycles.
- **Strobes.** Same parameters. Required response:
  - `lv_o` high for exactly 8 cycles per active line, 2 pulses per frame;
  - `fv_o` high for 40 consecutive cycles per frame;
  - no 0x00/0xFF word anywhere while `lv_o` = 1.
- **Enable and stop.** Pulse `en_i` high for 1 cycle, then drop it in mid-frame. Required response:
  - exactly one full 60-word frame is emitted;
  - `busy_o` is high for exactly 60 cycles;
  - the output then holds 0x00.
- **Pattern change.** Switch `pattern_i` from 2 to 1 during line 1. Required response: the rest of that frame keeps stripes 0xEB/0x10; the next frame carries 80/10 black.
- **Asynchronous reset.** Assert `gen_rst_n` low during an SAV. Required response:
  - outputs go to their reset values with no clock edge;
  - after release with `en_i` high, the stream restarts at EAV `FF` with `frame_start_o` = 1.
- **Loopback.** Run default parameters into `detector` for 3 frames. Required response: the detector reports 720 active lines and 2560 active words per line, with no TRS errors.
